// File: rtl/mult_div_pkg.sv
// rtl/mult_div_pkg.sv - shared types and constants for the MULT/DIV/DIVM sequencer
package mult_div_pkg;

    localparam int DEFAULT_WIDTH = 32;
    localparam int CNT_W         = $clog2(DEFAULT_WIDTH + 1);

    localparam logic [1:0] OP_NONE = 2'b00;
    localparam logic [1:0] OP_MULT = 2'b01;
    localparam logic [1:0] OP_DIV  = 2'b10;
    localparam logic [1:0] OP_DIVM = 2'b11;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_MULT,
        ST_DIV,
        ST_FIX,
        ST_DONE
    } state_e;

    function automatic int cnt_width(input int w);
        return $clog2(w + 1);
    endfunction

endpackage

// File: rtl/mult_div_step.sv
// rtl/mult_div_step.sv - one combinational iteration: shift-add multiply or restoring divide
module mult_div_step
    import mult_div_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             is_div_i,
    input  logic [WIDTH-1:0] hi_i,
    input  logic [WIDTH-1:0] lo_i,
    input  logic [WIDTH-1:0] b_i,
    output logic [WIDTH-1:0] hi_o,
    output logic [WIDTH-1:0] lo_o
);

    logic [WIDTH:0]   sum;
    logic [WIDTH:0]   shifted;
    logic [WIDTH-1:0] diff;
    logic             ge;

    always_comb begin
        sum     = {1'b0, hi_i} + (lo_i[0] ? {1'b0, b_i} : '0);
        shifted = {hi_i, lo_i[WIDTH-1]};
        // Magnitude compare rather than the borrow bit so a zero divisor
        // still yields an all-ones quotient.
        ge      = (shifted >= {1'b0, b_i});
        diff    = shifted[WIDTH-1:0] - b_i;
        hi_o    = sum[WIDTH:1];
        lo_o    = {sum[0], lo_i[WIDTH-1:1]};
        if (is_div_i) begin
            if (ge) begin
                hi_o = diff;
                lo_o = {lo_i[WIDTH-2:0], 1'b1};
            end else begin
                hi_o = shifted[WIDTH-1:0];
                lo_o = {lo_i[WIDTH-2:0], 1'b0};
            end
        end
    end

endmodule

// File: rtl/mult_div_ctrl.sv
// rtl/mult_div_ctrl.sv - MULT/DIV/DIVM sequencer owning HI/LO; DIV_ZERO_TRAP_EN enables the divide-by-zero trap
module mult_div_ctrl
    import mult_div_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start_i,
    input  logic [1:0]       op_i,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    output logic             busy_o,
    output logic             done_o,
    output logic             div_zero_o,
    output logic [WIDTH-1:0] hi_o,
    output logic [WIDTH-1:0] lo_o,
    output logic             hi_we_o,
    output logic             lo_we_o
);

    localparam int             CW   = cnt_width(WIDTH);
    localparam logic [CW-1:0]  LAST = CW'(WIDTH - 1);

    state_e           state_q;
    logic [CW-1:0]    cnt_q;
    logic [WIDTH-1:0] b_mag_q;
    logic [WIDTH-1:0] acc_hi_q;
    logic [WIDTH-1:0] acc_lo_q;
    logic             neg_res_q;
    logic             neg_a_q;
    logic             is_div_q;
    logic             busy_q;
    logic             done_q;
    logic             dz_q;
    logic             we_q;
    logic [WIDTH-1:0] hi_q;
    logic [WIDTH-1:0] lo_q;

    logic [WIDTH-1:0]   a_mag_d;
    logic [WIDTH-1:0]   b_mag_d;
    logic               is_div_op;
    logic               accept;
    logic [WIDTH-1:0]   step_hi;
    logic [WIDTH-1:0]   step_lo;
    logic [2*WIDTH-1:0] prod;
    logic [2*WIDTH-1:0] prod_fix_d;
    logic [WIDTH-1:0]   quo_fix_d;
    logic [WIDTH-1:0]   rem_fix_d;

    // -2^(WIDTH-1) negates to itself, which read as unsigned is the right magnitude.
    assign a_mag_d   = a_i[WIDTH-1] ? -a_i : a_i;
    assign b_mag_d   = b_i[WIDTH-1] ? -b_i : b_i;
    assign is_div_op = (op_i == OP_DIV) || (op_i == OP_DIVM);
    // busy_q is still high during the done cycle, which holds off back-to-back starts.
    assign accept    = (state_q == ST_IDLE) && !busy_q && start_i && (op_i != OP_NONE);

    assign prod       = {acc_hi_q, acc_lo_q};
    assign prod_fix_d = neg_res_q ? -prod : prod;
    assign quo_fix_d  = neg_res_q ? -acc_lo_q : acc_lo_q;
    assign rem_fix_d  = neg_a_q ? -acc_hi_q : acc_hi_q;

    mult_div_step #(
        .WIDTH(WIDTH)
    ) u_step (
        .is_div_i (is_div_q),
        .hi_i     (acc_hi_q),
        .lo_i     (acc_lo_q),
        .b_i      (b_mag_q),
        .hi_o     (step_hi),
        .lo_o     (step_lo)
    );

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            b_mag_q   <= '0;
            acc_hi_q  <= '0;
            acc_lo_q  <= '0;
            neg_res_q <= 1'b0;
            neg_a_q   <= 1'b0;
            is_div_q  <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            dz_q      <= 1'b0;
            we_q      <= 1'b0;
            hi_q      <= '0;
            lo_q      <= '0;
        end else begin
            done_q <= 1'b0;
            dz_q   <= 1'b0;
            we_q   <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    busy_q <= 1'b0;
                    if (accept) begin
                        busy_q    <= 1'b1;
                        cnt_q     <= '0;
                        b_mag_q   <= b_mag_d;
                        acc_hi_q  <= '0;
                        acc_lo_q  <= a_mag_d;
                        neg_res_q <= a_i[WIDTH-1] ^ b_i[WIDTH-1];
                        neg_a_q   <= a_i[WIDTH-1];
                        is_div_q  <= is_div_op;
                        if (is_div_op) begin
`ifdef DIV_ZERO_TRAP_EN
                            if (b_i == '0)
                                state_q <= ST_DONE;
                            else
`endif
                                state_q <= ST_DIV;
                        end else begin
                            state_q <= ST_MULT;
                        end
                    end
                end
                ST_MULT, ST_DIV: begin
                    acc_hi_q <= step_hi;
                    acc_lo_q <= step_lo;
                    cnt_q    <= cnt_q + 1'b1;
                    if (cnt_q == LAST)
                        state_q <= ST_FIX;
                end
                ST_FIX: begin
                    if (is_div_q) begin
                        acc_hi_q <= rem_fix_d;
                        acc_lo_q <= quo_fix_d;
                    end else begin
                        {acc_hi_q, acc_lo_q} <= prod_fix_d;
                    end
                    state_q <= ST_DONE;
                end
                ST_DONE: begin
                    done_q  <= 1'b1;
                    cnt_q   <= '0;
                    state_q <= ST_IDLE;
`ifdef DIV_ZERO_TRAP_EN
                    if (is_div_q && (b_mag_q == '0))
                        dz_q <= 1'b1;
                    else
`endif
                    begin
                        we_q <= 1'b1;
                        hi_q <= acc_hi_q;
                        lo_q <= acc_lo_q;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign busy_o     = busy_q;
    assign done_o     = done_q;
    assign div_zero_o = dz_q;
    assign hi_o       = hi_q;
    assign lo_o       = lo_q;
    assign hi_we_o    = we_q;
    assign lo_we_o    = we_q;

endmodule

// File: doc/mult_div_ctrl.md
# mult_div_ctrl

Multicycle sequencer for the MULT, DIV and DIVM instructions. It sits beside the main control unit and owns the HI/LO result path. When the control unit reaches the execute step of one of these instructions, it hands the operands from RegA/RegB to this block and stalls. This block iterates one bit per cycle, then returns the 64-bit result with write strobes for HI and LO, or raises a divide-by-zero indication.

## Interface
Parameters:
- `WIDTH`, default 32: operand width. HI/LO are each `WIDTH` bits.

Ports:
- `clock`  in  1: single clock, rising edge.
- `reset`  in  1: asynchronous, active-low.
- `start_i`  in  1: request from the control unit, sampled only in IDLE.
- `op_i`  in  2: operation. 00 = none, 01 = MULT, 10 = DIV, 11 = DIVM. DIVM is sequenced identically to DIV; only the operand source differs upstream.
- `a_i`  in  WIDTH: multiplicand or dividend (RegA).
- `b_i`  in  WIDTH: multiplier or divisor (RegB or MDR for DIVM).
- `busy_o`  out  1: high from the cycle after acceptance until `done_o`, inclusive.
- `done_o`  out  1: one-cycle completion pulse.
- `div_zero_o`  out  1: one-cycle pulse with `done_o` when the divisor is 0 (only when `DIV_ZERO_TRAP_EN` is defined).
- `hi_o`, `lo_o`  out  WIDTH each: result registers, held until the next completion.
- `hi_we_o`, `lo_we_o`  out  1 each: HI/LO write strobes, equal to `done_o & ~div_zero_o`.

## Operation
- States: IDLE, MULT, DIV, FIX, DONE.
- IDLE:
  - `start_i=1` with op 01 latches |a|, |b| and result signs, clears the iteration counter and goes to MULT.
  - `start_i=1` with op 10 or 11 latches the same values and goes to DIV.
  - op 00, or `start_i=0`, stays in IDLE.
- MULT: unsigned shift-add on magnitudes, one multiplier bit per cycle. After WIDTH iterations, go to FIX.
- DIV: restoring division on magnitudes, one quotient bit per cycle, with a WIDTH+1-bit partial remainder. After WIDTH iterations, go to FIX.
- FIX: apply signs.
  - Product is negated if sign(a) XOR sign(b).
  - Quotient is negated if sign(a) XOR sign(b).
  - Remainder takes the sign of the dividend.
  - Division truncates toward zero.
  - MULT result: `hi_o` = product[63:32], `lo_o` = product[31:0].
  - DIV result: `lo_o` = quotient, `hi_o` = remainder.
- DONE: assert `done_o` and the write strobes for one cycle, then go to IDLE.
- Arithmetic: magnitude of -2^(WIDTH-1) is handled as unsigned 2^(WIDTH-1). Quotient of -2^31 / -1 wraps to 0x80000000 with remainder 0; no overflow flag.
- `start_i` while busy is ignored, and no input is re-sampled. Operands are captured at acceptance, so `a_i`/`b_i` may change afterwards.
- Asynchronous reset, including mid-operation:
  - State goes to IDLE and the counter to 0.
  - `hi_o`, `lo_o` reset to 0.
  - `busy_o`, `done_o`, `div_zero_o`, `hi_we_o`, `lo_we_o` reset to 0.
  - No partial result is ever written.

## Timing
- Acceptance edge = T0 (IDLE, `start_i=1`, valid op).
- `busy_o` rises after T0.
- MULT/DIV occupies edges T1..T32, FIX is T33, DONE is T34.
- `done_o` is high for the cycle following T34, and `hi_o`/`lo_o` are already valid in that cycle.
- Total latency from acceptance to `done_o`: 35 cycles (WIDTH+3).
- Back-to-back: a new `start_i` is accepted no earlier than the cycle after the `done_o` cycle.
- All outputs are registered; no combinational path from inputs to outputs.

## Configuration
- `DIV_ZERO_TRAP_EN` defined:
  - A DIV/DIVM with `b_i == 0` goes IDLE -> DONE directly.
  - `done_o` and `div_zero_o` pulse together 2 cycles after acceptance.
  - Strobes stay low and `hi_o`/`lo_o` are unchanged.
  - The control unit uses the pulse to enter its divide-by-zero exception state.
- Undefined:
  - `div_zero_o` is tied to 0.
  - Division by zero runs the full sequence and produces `lo_o` = 0xFFFFFFFF (negated if the dividend is negative) and `hi_o` = `a_i`.

## Structure
- Package `mult_div_pkg` holds:
  - the state enum;
  - op encodings `OP_NONE`, `OP_MULT`, `OP_DIV`, `OP_DIVM`;
  - the default `WIDTH` of 32;
  - the counter width, `$clog2(WIDTH+1)`.
- One sub-module, `mult_div_step`: combinational single-iteration datapath (add-shift or subtract-compare-shift, selected by op). The FSM, counter and registers stay in `mult_div_ctrl`.

## Test plan
- MULT a=7, b=-3 (0xFFFFFFFD) -> `done_o` 35 cycles after acceptance; `hi_o`=0xFFFFFFFF, `lo_o`=0xFFFFFFEB; both strobes high for 1 cycle.
- DIV a=-7, b=2 -> `lo_o`=0xFFFFFFFD (-3), `hi_o`=0xFFFFFFFF (-1).
- DIV a=0x80000000, b=0xFFFFFFFF -> `lo_o`=0x80000000, `hi_o`=0; MULT 0x80000000 × 0x80000000 -> `hi_o`=0x40000000, `lo_o`=0.
- DIV a=5, b=0:
  - with `DIV_ZERO_TRAP_EN`: `done_o`+`div_zero_o` 2 cycles after acceptance, strobes 0, HI/LO unchanged;
  - without it: `lo_o`=0xFFFFFFFF, `hi_o`=5 after 35 cycles.
- `start_i` pulsed with new operands at cycle 10 of a MULT -> ignored; the original result is produced and exactly one `done_o` is seen.
- Assert `reset` low at cycle 20 of a DIV -> all outputs 0 immediately; after release, IDLE accepts a new MULT 3×4 -> `lo_o`=12, `hi_o`=0.
